// File: rtl/spi_ram_burst_slave_if.sv
// Serial-side bundle of the SPI RAM slave: select, data lines, abort pulse and FSM state.
interface spi_ram_burst_slave_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic       frame_err;
  logic [2:0] state_dbg;

  modport master (output SS_n, MOSI, input MISO, frame_err, state_dbg);
  modport slave  (input SS_n, MOSI, output MISO, frame_err, state_dbg);
endinterface

// File: rtl/spi_ram_burst_slave.sv
// SPI-slave-fronted single-port RAM with address/data commands and burst auto-increment.
// Frame: cmd[1:0] then P=max(ADDR_W,DATA_W) payload bits, MSB first, bounded by SS_n low.
module spi_ram_burst_slave #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  spi_ram_burst_slave_if.slave  bus
);

  localparam int P  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW = $clog2(P) + 1;
  localparam logic [CW-1:0]     LAST_PAY = CW'(P - 1);
  localparam logic [CW-1:0]     LAST_RD  = CW'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] INC      = (AUTO_INC != 0) ? ADDR_W'(1) : ADDR_W'(0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    PAYLOAD  = 3'd2,
    WR_BURST = 3'd3,
    RD_LOAD  = 3'd4,
    RD_SHIFT = 3'd5,
    WAIT_SS  = 3'd6
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [1:0]        cmd;
  logic [P-2:0]      sr;
  logic [P-1:0]      pay;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] tx;
  logic              miso_q;
  logic              err_q;

  logic word_end, shift_end;
  logic ram_we, wr_load, rd_load, rd_fetch, err_set;

  // Current payload including the bit being sampled on this edge.
  assign pay       = {sr, bus.MOSI};
  assign word_end  = (cnt == LAST_PAY);
  assign shift_end = (cnt == LAST_RD);

  assign bus.MISO      = miso_q;
  assign bus.frame_err = err_q;
  assign bus.state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.SS_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:     state_nx = CMD;
        CMD:      state_nx = PAYLOAD;
        PAYLOAD:
          if (word_end) begin
            case (cmd)
              2'b01:   state_nx = WR_BURST;
              2'b11:   state_nx = RD_LOAD;
              default: state_nx = WAIT_SS;
            endcase
          end
        RD_LOAD:  state_nx = RD_SHIFT;
        RD_SHIFT: if (shift_end) state_nx = RD_LOAD;
        default:  state_nx = state;
      endcase
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    wr_load  = 1'b0;
    rd_load  = 1'b0;
    rd_fetch = 1'b0;
    err_set  = 1'b0;
    if (bus.SS_n) begin
      // A rise is clean only between whole burst words or outside a header.
      err_set = (state == CMD) || (state == PAYLOAD) ||
                ((state == WR_BURST) && (cnt != '0));
    end else begin
      case (state)
        PAYLOAD:
          if (word_end) begin
            case (cmd)
              2'b00:   wr_load = 1'b1;
              2'b01:   ram_we  = 1'b1;
              2'b10:   rd_load = 1'b1;
              default: ;
            endcase
          end
        WR_BURST: ram_we   = word_end;
        RD_LOAD:  rd_fetch = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      sr      <= '0;
      cnt     <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      tx      <= '0;
      miso_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sr    <= pay[P-2:0];
      err_q <= err_set;

      if (!bus.SS_n && (state == IDLE || state == CMD))
        cmd <= {cmd[0], bus.MOSI};

      if (bus.SS_n) begin
        cnt <= '0;
      end else begin
        case (state)
          PAYLOAD, WR_BURST: cnt <= word_end  ? '0 : cnt + 1'b1;
          RD_SHIFT:          cnt <= shift_end ? '0 : cnt + 1'b1;
          default:           cnt <= '0;
        endcase
      end

      if (wr_load)     wr_addr <= pay[ADDR_W-1:0];
      else if (ram_we) wr_addr <= wr_addr + INC;

      if (rd_load)       rd_addr <= pay[ADDR_W-1:0];
      else if (rd_fetch) rd_addr <= rd_addr + INC;

      // MISO holds 0 in the inter-word gap and whenever not shifting read data.
      if (rd_fetch) begin
        tx     <= mem[rd_addr] << 1;
        miso_q <= mem[rd_addr][DATA_W-1];
      end else if (!bus.SS_n && state == RD_SHIFT && !shift_end) begin
        tx     <= tx << 1;
        miso_q <= tx[DATA_W-1];
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_addr] <= pay[DATA_W-1:0];
  end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Directed bench for spi_ram_burst_slave: default, AUTO_INC=0 and ADDR_W=10 instances share the serial lines.
module tb_spi_ram_burst_slave;

  logic clk;
  logic rst_n;
  logic ss_n;
  logic mosi;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  spi_ram_burst_slave_if b0 ();
  spi_ram_burst_slave_if b1 ();
  spi_ram_burst_slave_if b2 ();

  assign b0.SS_n = ss_n;  assign b0.MOSI = mosi;
  assign b1.SS_n = ss_n;  assign b1.MOSI = mosi;
  assign b2.SS_n = ss_n;  assign b2.MOSI = mosi;

  spi_ram_burst_slave #(.ADDR_W(8),  .DATA_W(8), .AUTO_INC(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  spi_ram_burst_slave #(.ADDR_W(8),  .DATA_W(8), .AUTO_INC(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  spi_ram_burst_slave #(.ADDR_W(10), .DATA_W(8), .AUTO_INC(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_miso(input int d);
    case (d)
      0:       return b0.MISO;
      1:       return b1.MISO;
      default: return b2.MISO;
    endcase
  endfunction

  function automatic logic get_err(input int d);
    case (d)
      0:       return b0.frame_err;
      1:       return b1.frame_err;
      default: return b2.frame_err;
    endcase
  endfunction

  // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ss_n = 1'b0;
      mosi = v[i];
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [1:0] c, input logic [31:0] p, input int pbits);
    send_bits(32'(c), 2);
    send_bits(p, pbits);
  endtask

  task automatic end_frame(input int d, input logic exp_err, input string tag);
    ss_n = 1'b1;
    mosi = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, 32'(get_err(d)), 32'(exp_err));
    check({tag, "_miso"}, 32'(get_miso(d)), 32'd0);
  endtask

  task automatic read_words(input int d, input int n, input int dw, input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    for (int w = 0; w < n; w++) begin
      got = '0;
      for (int b = 0; b < dw; b++) begin
        ss_n = 1'b0;
        mosi = 1'b0;
        @(negedge clk);
        got = {got[30:0], get_miso(d)};
      end
      exp = exp_q.pop_front();
      check($sformatf("%s_w%0d", tag, w), got, exp);
      @(negedge clk);
      check($sformatf("%s_gap%0d", tag, w), 32'(get_miso(d)), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_miso0",  32'(b0.MISO), 32'd0);
    check("rst_err0",   32'(b0.frame_err), 32'd0);
    check("rst_state0", 32'(b0.state_dbg), 32'd0);
    check("rst_state2", 32'(b2.state_dbg), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write then read
    send_frame(2'b00, 32'h10, 8); end_frame(0, 1'b0, "t1_a");
    send_frame(2'b01, 32'hA5, 8); end_frame(0, 1'b0, "t1_b");
    send_frame(2'b10, 32'h10, 8); end_frame(0, 1'b0, "t1_c");
    send_frame(2'b11, 32'h00, 8);
    exp_q.push_back(32'hA5);
    read_words(0, 1, 8, "t1_rd");
    end_frame(0, 1'b0, "t1_d");

    // Write burst with address wrap, then read burst
    send_frame(2'b00, 32'hFE, 8); end_frame(0, 1'b0, "t2_a");
    send_frame(2'b01, 32'h11, 8);
    send_bits(32'h22, 8);
    send_bits(32'h33, 8);
    end_frame(0, 1'b0, "t2_wb");
    send_frame(2'b10, 32'hFE, 8); end_frame(0, 1'b0, "t2_c");
    send_frame(2'b11, 32'h00, 8);
    exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
    read_words(0, 3, 8, "t2_rd");
    end_frame(0, 1'b0, "t2_d");

    // AUTO_INC=0 instance: burst overwrites and reads repeat one address
    send_frame(2'b00, 32'h05, 8); end_frame(1, 1'b0, "t3_a");
    send_frame(2'b01, 32'h01, 8);
    send_bits(32'h02, 8);
    end_frame(1, 1'b0, "t3_b");
    send_frame(2'b10, 32'h05, 8); end_frame(1, 1'b0, "t3_c");
    send_frame(2'b11, 32'h00, 8);
    exp_q.push_back(32'h02); exp_q.push_back(32'h02);
    read_words(1, 2, 8, "t3_rd");
    end_frame(1, 1'b0, "t3_d");

    // Abort mid-payload
    send_frame(2'b00, 32'h20, 8); end_frame(0, 1'b0, "t4_a");
    send_frame(2'b01, 32'h5A, 8); end_frame(0, 1'b0, "t4_b");
    send_frame(2'b00, 32'h20, 8); end_frame(0, 1'b0, "t4_c");
    send_bits(32'h1, 2);
    send_bits(32'h3F, 6);
    ss_n = 1'b1;
    @(negedge clk);
    check("t4_err_on", 32'(b0.frame_err), 32'd1);
    @(negedge clk);
    check("t4_err_off", 32'(b0.frame_err), 32'd0);
    send_frame(2'b10, 32'h20, 8); end_frame(0, 1'b0, "t4_d");
    send_frame(2'b11, 32'h00, 8);
    exp_q.push_back(32'h5A);
    read_words(0, 1, 8, "t4_keep");
    end_frame(0, 1'b0, "t4_e");
    send_frame(2'b00, 32'h21, 8); end_frame(0, 1'b0, "t4_f");
    send_frame(2'b01, 32'hC3, 8); end_frame(0, 1'b0, "t4_g");
    send_frame(2'b10, 32'h21, 8); end_frame(0, 1'b0, "t4_h");
    send_frame(2'b11, 32'h00, 8);
    exp_q.push_back(32'hC3);
    read_words(0, 1, 8, "t4_next");
    end_frame(0, 1'b0, "t4_i");

    // Reset during RD_SHIFT, then read from the reset rd_addr
    send_frame(2'b10, 32'hFE, 8); end_frame(0, 1'b0, "t5_a");
    send_frame(2'b11, 32'h00, 8);
    repeat (4) @(negedge clk);
    check("t5_pre_miso", 32'(b0.MISO), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_miso", 32'(b0.MISO), 32'd0);
    check("t5_rst_state", 32'(b0.state_dbg), 32'd0);
    ss_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(2'b11, 32'h00, 8);
    exp_q.push_back(32'h33);
    read_words(0, 1, 8, "t5_rd");
    end_frame(0, 1'b0, "t5_b");

    // ADDR_W=10 instance: 12-bit headers, wrap from 0x3FF
    send_frame(2'b00, 32'h3FF, 10); end_frame(2, 1'b0, "t6_a");
    send_frame(2'b01, 32'h0AB, 10);
    send_bits(32'h0CD, 10);
    end_frame(2, 1'b0, "t6_b");
    send_frame(2'b10, 32'h3FF, 10); end_frame(2, 1'b0, "t6_c");
    send_frame(2'b11, 32'h000, 10);
    exp_q.push_back(32'hAB); exp_q.push_back(32'hCD);
    read_words(2, 2, 8, "t6_rd");
    end_frame(2, 1'b0, "t6_d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
